// File: rtl/ascii_pkg.sv
// Shared types and constants for the ASCII checksum stream block.
package ascii_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic       MODE_SUM  = 1'b0;
  localparam logic       MODE_XOR  = 1'b1;
  localparam logic [7:0] ASCII_NUL = 8'h00;

endpackage

// File: rtl/ascii_acc_unit.sv
// Checksum accumulator and length counter. A start load seeds both from the
// first byte; later updates fold in each non-NUL byte.
module ascii_acc_unit
  import ascii_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int SUM_W  = 16,
  parameter int LEN_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              upd,
  input  logic              mode,
  input  logic [DATA_W-1:0] data,
  output logic [SUM_W-1:0]  acc,
  output logic [LEN_W-1:0]  len
);

  logic [SUM_W-1:0] acc_q, acc_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [SUM_W-1:0] base;
  logic [SUM_W-1:0] ext;
  logic [SUM_W-1:0] next_acc;
  logic             is_nul;

  always_comb begin
    is_nul   = (data == DATA_W'(ASCII_NUL));
    ext      = SUM_W'(data);
    base     = start ? '0 : acc_q;
    next_acc = (mode == MODE_XOR) ? (base ^ ext) : (base + ext);
    acc_d    = acc_q;
    len_d    = len_q;
    if (start) begin
      acc_d = is_nul ? '0 : next_acc;
      len_d = is_nul ? '0 : LEN_W'(1);
    end else if (upd && !is_nul) begin
      acc_d = next_acc;
      len_d = len_q + LEN_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      len_q <= '0;
    end else begin
      acc_q <= acc_d;
      len_q <= len_d;
    end
  end

  assign acc = acc_q;
  assign len = len_q;

endmodule

// File: rtl/ascii_checksum_stream.sv
// Frame-based ASCII checksum (sum or XOR) over a valid/ready byte stream.
// Optional ASCII_STRICT_EN adds out_nonascii and suppresses matches on bytes with bit 7 set.
module ascii_checksum_stream
  import ascii_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int MAX_LEN = 24,
  parameter int SUM_W   = 16,
  parameter int LEN_W   = 5,
  parameter int TARGET  = 2111
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SUM_W-1:0]  out_sum,
  output logic [LEN_W-1:0]  out_len,
  output logic              out_match,
  output logic              out_trunc,
`ifdef ASCII_STRICT_EN
  output logic              out_nonascii,
`endif
  output state_e            dbg_state
);

  // Handshake: a byte transfers on in_valid && in_ready; a result transfers
  // on out_valid && out_ready. in_ready is low only while a result is held.

  state_e           state_q, state_d;
  logic             mode_q, mode_d;
  logic             trunc_q, trunc_d;
  logic             accept, start, upd;
  logic             is_nul, at_limit, term;
  logic             eff_mode;
  logic             nonascii;
  logic [SUM_W-1:0] acc;
  logic [LEN_W-1:0] len;

  always_comb begin
    in_ready  = (state_q != DONE);
    out_valid = (state_q == DONE);
    accept    = in_valid && in_ready;
    start     = accept && (state_q == IDLE);
    upd       = accept && (state_q == ACCUM);
    is_nul    = (in_data == DATA_W'(ASCII_NUL));
    // The byte that brings the count to MAX_LEN; a NUL never counts.
    at_limit  = (state_q == ACCUM) && !is_nul && (len == LEN_W'(MAX_LEN - 1));
    term      = is_nul || in_last || at_limit;
    eff_mode  = start ? mode : mode_q;

    state_d = state_q;
    mode_d  = mode_q;
    trunc_d = trunc_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mode_d  = mode;
          trunc_d = 1'b0;
          state_d = term ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (upd && term) begin
          trunc_d = at_limit && !in_last;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= MODE_SUM;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      trunc_q <= trunc_d;
    end
  end

  ascii_acc_unit #(
    .DATA_W (DATA_W),
    .SUM_W  (SUM_W),
    .LEN_W  (LEN_W)
  ) u_acc (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .upd   (upd),
    .mode  (eff_mode),
    .data  (in_data),
    .acc   (acc),
    .len   (len)
  );

`ifdef ASCII_STRICT_EN
  logic nonascii_q, nonascii_d;

  always_comb begin
    nonascii_d = nonascii_q;
    if (start)    nonascii_d = in_data[7];
    else if (upd) nonascii_d = nonascii_q | in_data[7];
  end

  always_ff @(posedge clk) begin
    if (rst) nonascii_q <= 1'b0;
    else     nonascii_q <= nonascii_d;
  end

  assign nonascii     = nonascii_q;
  assign out_nonascii = nonascii_q;
`else
  assign nonascii = 1'b0;
`endif

  assign out_sum   = acc;
  assign out_len   = len;
  assign out_match = (state_q == DONE) && (acc == SUM_W'(TARGET)) && !nonascii;
  assign out_trunc = trunc_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ascii_checksum_stream.sv
// Directed bench for ascii_checksum_stream; build with +define+ASCII_STRICT_EN to cover out_nonascii.
module tb_ascii_checksum_stream;
  import ascii_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        mode;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic [4:0]  out_len;
  logic        out_match;
  logic        out_trunc;
`ifdef ASCII_STRICT_EN
  logic        out_nonascii;
`endif
  state_e      dbg_state;

  int total = 0;
  int bad   = 0;

  ascii_checksum_stream dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_len   (out_len),
    .out_match (out_match),
    .out_trunc (out_trunc),
`ifdef ASCII_STRICT_EN
    .out_nonascii (out_nonascii),
`endif
    .dbg_state (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Driver: present one byte, wait (bounded) for in_ready, transfer it.
  task automatic send(input logic [7:0] d, input logic l, input logic m);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    mode     = m;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $error("FAIL send_timeout: observed in_ready=0 expected=1");
    end
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    chk("consume_valid_low", 32'(out_valid), 0);
    chk("consume_idle", 32'(dbg_state), 32'(IDLE));
  endtask

  string hello;

  initial begin
    rst       = 1'b1;
    mode      = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_last   = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_sum", 32'(out_sum), 0);
    chk("rst_len", 32'(out_len), 0);
    chk("rst_match", 32'(out_match), 0);
    chk("rst_trunc", 32'(out_trunc), 0);
    rst = 1'b0;
    tick();

    // "Hello CheckSum Project!" + NUL, sum mode: 2111, 23 chars
    hello = "Hello CheckSum Project!";
    for (int i = 0; i < hello.len(); i++) send(hello[i], 1'b0, 1'b0);
    chk("hello_no_early_valid", 32'(out_valid), 0);
    send(8'h00, 1'b0, 1'b0);
    chk("hello_valid", 32'(out_valid), 1);
    chk("hello_sum", 32'(out_sum), 2111);
    chk("hello_len", 32'(out_len), 23);
    chk("hello_match", 32'(out_match), 1);
    chk("hello_trunc", 32'(out_trunc), 0);
`ifdef ASCII_STRICT_EN
    chk("hello_nonascii", 32'(out_nonascii), 0);
`endif
    consume();

    // "AB" XOR with in_last on 'B': 0x41 ^ 0x42 = 3
    send(8'h41, 1'b0, 1'b1);
    send(8'h42, 1'b1, 1'b1);
    chk("xor_valid", 32'(out_valid), 1);
    chk("xor_sum", 32'(out_sum), 3);
    chk("xor_len", 32'(out_len), 2);
    chk("xor_match", 32'(out_match), 0);
    consume();

    // 24 'A' closes by length limit: 24*65 = 1560, then stall 5 cycles
    out_ready = 1'b0;
    for (int i = 0; i < 24; i++) send(8'h41, 1'b0, 1'b0);
    chk("trunc_valid", 32'(out_valid), 1);
    chk("trunc_sum", 32'(out_sum), 1560);
    chk("trunc_len", 32'(out_len), 24);
    chk("trunc_flag", 32'(out_trunc), 1);
    in_valid = 1'b1;
    in_data  = 8'h41;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_in_ready", 32'(in_ready), 0);
      chk("stall_valid", 32'(out_valid), 1);
      chk("stall_sum", 32'(out_sum), 1560);
      chk("stall_len", 32'(out_len), 24);
    end
    // Byte 25 waits for the result handshake, then starts a new frame
    out_ready = 1'b1;
    send(8'h41, 1'b0, 1'b0);
    chk("b25_valid", 32'(out_valid), 0);
    chk("b25_state", 32'(dbg_state), 32'(ACCUM));
    chk("b25_len", 32'(out_len), 1);
    chk("b25_trunc_cleared", 32'(out_trunc), 0);
    for (int i = 0; i < 4; i++) send(8'h41, 1'b0, 1'b0);
    send(8'h41, 1'b1, 1'b0);
    chk("tail_sum", 32'(out_sum), 390);
    chk("tail_len", 32'(out_len), 6);
    chk("tail_trunc", 32'(out_trunc), 0);
    consume();

    // NUL first: empty frame
    send(8'h00, 1'b0, 1'b0);
    chk("nul_valid", 32'(out_valid), 1);
    chk("nul_sum", 32'(out_sum), 0);
    chk("nul_len", 32'(out_len), 0);
    chk("nul_match", 32'(out_match), 0);
    consume();

    // NUL together with in_last: NUL not counted, frame closes once
    send(8'h41, 1'b0, 1'b0);
    send(8'h00, 1'b1, 1'b0);
    chk("nullast_sum", 32'(out_sum), 65);
    chk("nullast_len", 32'(out_len), 1);
    consume();
    chk("nullast_once", 32'(out_valid), 0);

    // Mode change mid-frame ignored: sum 65+66 = 131
    send(8'h41, 1'b0, 1'b0);
    send(8'h42, 1'b1, 1'b1);
    chk("modechg_sum", 32'(out_sum), 131);
    consume();

    // Reset after 3 bytes of a frame
    send(8'h41, 1'b0, 1'b0);
    send(8'h42, 1'b0, 1'b0);
    send(8'h43, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_state", 32'(dbg_state), 32'(IDLE));
    chk("midrst_sum", 32'(out_sum), 0);
    chk("midrst_len", 32'(out_len), 0);
    chk("midrst_valid", 32'(out_valid), 0);
    chk("midrst_in_ready", 32'(in_ready), 1);

`ifdef ASCII_STRICT_EN
    // 0xC1 + 15*0x7F + 0x0D = 193 + 1905 + 13 = 2111
    send(8'hC1, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) send(8'h7F, 1'b0, 1'b0);
    send(8'h0D, 1'b1, 1'b0);
    chk("strict_sum", 32'(out_sum), 2111);
    chk("strict_nonascii", 32'(out_nonascii), 1);
    chk("strict_match", 32'(out_match), 0);
    consume();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ascii_checksum_stream.md
Name: ascii_checksum_stream

Overview:
- Streaming successor to the fixed 192-bit ASCII string checker.
- Accepts one ASCII byte per cycle over a valid/ready handshake and accumulates a checksum over one frame, either as an additive sum or as an XOR.
- A frame ends on a NUL byte, on `in_last`, or on reaching `MAX_LEN` bytes. The block then reports the checksum, the frame length, and whether the checksum matches `TARGET`.
- Sits between the character source (UART or ROM string reader) and the status LEDs/display.

Parameters:
- `DATA_W`, 8, byte width of each character.
- `MAX_LEN`, 24, maximum characters per frame (≥ 2).
- `SUM_W`, 16, accumulator and checksum width.
- `LEN_W`, 5, length counter width; must hold `MAX_LEN`.
- `TARGET`, 2111, expected checksum for the match flag.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous reset, active-high.
- `mode`  in  1  0 = additive sum, 1 = XOR; sampled on the first byte of a frame.
- `in_valid`  in  1  input byte valid.
- `in_ready`  out  1  block can accept a byte.
- `in_data`  in  `DATA_W`  ASCII character.
- `in_last`  in  1  current byte is the final byte of the frame.
- `out_valid`  out  1  frame result valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_sum`  out  `SUM_W`  frame checksum.
- `out_len`  out  `LEN_W`  characters counted; a NUL terminator is not counted.
- `out_match`  out  1  `out_sum == TARGET`.
- `out_trunc`  out  1  frame closed by the `MAX_LEN` limit.

Behaviour:
- Single clock `clk`. Reset is synchronous and active-high on `rst`.
- Reset values:
  - state = IDLE, `in_ready` = 1, `out_valid` = 0.
  - `out_sum` = 0, `out_len` = 0, `out_match` = 0, `out_trunc` = 0.
  - accumulator = 0, length counter = 0.
- Handshakes:
  - An input byte is accepted on a cycle with `in_valid && in_ready`.
  - A result is consumed on a cycle with `out_valid && out_ready`.
- FSM:
  - IDLE: `in_ready` = 1. An accepted byte latches `mode` and loads the accumulator and counter.
    - Non-terminating byte: go to ACCUM.
    - Terminating byte: go directly to DONE.
  - ACCUM: `in_ready` = 1. Each accepted byte updates the accumulator and increments the length.
    - The byte is terminating if `in_data == 0`, or `in_last == 1`, or the count reaches `MAX_LEN` with this byte.
    - A terminating byte moves the FSM to DONE.
  - DONE: `in_ready` = 0 and `out_valid` = 1. Outputs are held stable until `out_ready`, then return to IDLE.
- Latency: `out_valid` rises on the cycle after the terminating byte is accepted.
- Arithmetic:
  - Sum mode: `acc = (acc + zero-extended byte) mod 2^SUM_W`.
  - XOR mode: `acc = acc ^ zero-extended byte`.
  - A NUL byte contributes nothing and does not increment the length.
- Boundary conditions:
  - NUL as the first byte: empty frame, `out_len` = 0, `out_sum` = 0.
  - `in_last` together with a NUL byte: NUL rules apply and the frame closes once.
  - The `MAX_LEN`-th byte closes the frame with `out_trunc` = 1, unless that byte also has `in_last` or is NUL.
  - Accumulator overflow wraps silently.
  - `mode` changes mid-frame are ignored.
  - `rst` mid-frame or in DONE: the partial frame is discarded and all outputs return to their reset values on the next edge.

Optional Feature:
- Macro `ASCII_STRICT_EN`.
- Defined:
  - Adds output `out_nonascii` (1 bit).
  - It is set if any accepted byte in the frame has bit 7 set, held in DONE, and cleared on frame start and on reset.
  - `out_match` is forced to 0 when `out_nonascii` is set.
- Undefined: the port does not exist and all bytes are treated as data.

Decomposition:
- Shared package `ascii_pkg`:
  - state enum {IDLE, ACCUM, DONE}.
  - `MODE_SUM` = 0, `MODE_XOR` = 1.
  - `ASCII_NUL` = 8'h00.
- One natural sub-module, `ascii_acc_unit`: the combinational sum/XOR update plus the registered accumulator and length counter.
- The FSM and handshake logic stay in the top module.

Test Plan:
- Stream "Hello CheckSum Project!" then NUL, `mode` = 0, `out_ready` = 1 → `out_sum` = 2111, `out_len` = 23, `out_match` = 1, `out_trunc` = 0, `out_valid` pulses 1 cycle after the NUL.
- "AB" with `in_last` on 'B', `mode` = 1 → `out_sum` = 0x0003, `out_len` = 2, `out_match` = 0.
- 30 bytes of 'A' with no terminator → frame closes at byte 24, `out_sum` = 1560, `out_len` = 24, `out_trunc` = 1; byte 25 is accepted only after the result handshake, as the start of a new frame.
- Result ready, `out_ready` held 0 for 5 cycles with `in_valid` = 1 → `in_ready` = 0 and outputs stable for 5 cycles; the result is consumed on the first `out_ready` cycle.
- NUL as the first byte → `out_len` = 0, `out_sum` = 0; `rst` asserted after 3 bytes of a frame → all outputs zero and state IDLE next cycle.
- With `ASCII_STRICT_EN` defined: a frame with byte 0xC1 and a sum equal to `TARGET` → `out_nonascii` = 1, `out_match` = 0.
